// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared event codes, FSM state encoding and event packing for the IR key event block
package ir_pkg;

    localparam int EVT_W = 10;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_REPEAT  = 2'd1;
    localparam logic [1:0] EVT_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_DLY = 2'd1,
        HOLD_RPT = 2'd2,
        SWITCH   = 2'd3
    } state_t;

    // Event word layout: {type[1:0], code[7:0]}
    function automatic logic [EVT_W-1:0] mk_evt(input logic [1:0] evt_type, input logic [7:0] code);
        return {evt_type, code};
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// rtl/ir_evt_fifo.sv - generic show-ahead synchronous FIFO with count, full and empty
module ir_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop_ok)  r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/ir_key_events.sv
// rtl/ir_key_events.sv - turns repeated IR command frames into PRESS/REPEAT/RELEASE key events
module ir_key_events
    import ir_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int RELEASE_MS      = 150,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    ir_cmd,
    input  logic                          ir_cmd_ready,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic [1:0]                    evt_type,
    output logic                          key_down,
    output logic [7:0]                    key_code,
    output logic                          evt_dropped,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_pre;
    logic             w_tick;
    logic [15:0]      r_rel_t;
    logic [15:0]      r_rep_t;
    logic             w_rel_exp;
    logic             w_rep_exp;
    logic             w_same;
    logic [7:0]       r_key_code;
    logic [7:0]       r_new_code;
    logic             r_key_down;
    logic             r_dropped;

    logic             w_push;
    logic [EVT_W-1:0] w_push_evt;
    logic             w_load_both;
    logic             w_load_rel;
    logic             w_load_rate;
    logic             w_clear_t;
    logic             w_key_we;
    logic [7:0]       w_key_d;
    logic             w_new_we;
    logic             w_down_set;
    logic             w_down_clr;

    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [EVT_W-1:0] w_head;
    logic [CW-1:0]    w_count;

    assign w_tick    = (r_pre == PW'(DIV - 1));
    assign w_rel_exp = w_tick && (r_rel_t == 16'd1);
    assign w_rep_exp = w_tick && (r_rep_t == 16'd1);
    assign w_same    = (ir_cmd == r_key_code);

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_pre <= '0;
        else                 r_pre <= r_pre + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (ir_cmd_ready) w_state_nxt = HOLD_DLY;
            end
            HOLD_DLY, HOLD_RPT: begin
                if (ir_cmd_ready) begin
                    if (!w_same) w_state_nxt = SWITCH;
                end else if (w_rel_exp) begin
                    w_state_nxt = IDLE;
                end else if (w_rep_exp) begin
                    w_state_nxt = HOLD_RPT;
                end
            end
            SWITCH:  w_state_nxt = HOLD_DLY;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Losing expiries simply fall through here and are not remembered
    always_comb begin
        w_push      = 1'b0;
        w_push_evt  = '0;
        w_load_both = 1'b0;
        w_load_rel  = 1'b0;
        w_load_rate = 1'b0;
        w_clear_t   = 1'b0;
        w_key_we    = 1'b0;
        w_key_d     = ir_cmd;
        w_new_we    = 1'b0;
        w_down_set  = 1'b0;
        w_down_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ir_cmd_ready) begin
                    w_push      = 1'b1;
                    w_push_evt  = mk_evt(EVT_PRESS, ir_cmd);
                    w_load_both = 1'b1;
                    w_key_we    = 1'b1;
                    w_down_set  = 1'b1;
                end
            end
            HOLD_DLY, HOLD_RPT: begin
                if (ir_cmd_ready) begin
                    if (w_same) begin
                        w_load_rel = 1'b1;
                    end else begin
                        w_push     = 1'b1;
                        w_push_evt = mk_evt(EVT_RELEASE, r_key_code);
                        w_new_we   = 1'b1;
                    end
                end else if (w_rel_exp) begin
                    w_push     = 1'b1;
                    w_push_evt = mk_evt(EVT_RELEASE, r_key_code);
                    w_down_clr = 1'b1;
                    w_clear_t  = 1'b1;
                end else if (w_rep_exp) begin
                    w_push      = 1'b1;
                    w_push_evt  = mk_evt(EVT_REPEAT, r_key_code);
                    w_load_rate = 1'b1;
                end
            end
            SWITCH: begin
                w_push      = 1'b1;
                w_push_evt  = mk_evt(EVT_PRESS, r_new_code);
                w_load_both = 1'b1;
                w_key_we    = 1'b1;
                w_key_d     = r_new_code;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rel_t <= '0;
            r_rep_t <= '0;
        end else begin
            if (w_load_both || w_load_rel)     r_rel_t <= 16'(RELEASE_MS);
            else if (w_clear_t)                r_rel_t <= '0;
            else if (w_tick && r_rel_t != '0)  r_rel_t <= r_rel_t - 16'd1;

            if (w_load_both)                   r_rep_t <= 16'(REPEAT_DELAY_MS);
            else if (w_load_rate)              r_rep_t <= 16'(REPEAT_RATE_MS);
            else if (w_clear_t)                r_rep_t <= '0;
            else if (w_tick && r_rep_t != '0)  r_rep_t <= r_rep_t - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_code <= '0;
            r_new_code <= '0;
            r_key_down <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            if (w_key_we) r_key_code <= w_key_d;
            if (w_new_we) r_new_code <= ir_cmd;
            if (w_down_set)      r_key_down <= 1'b1;
            else if (w_down_clr) r_key_down <= 1'b0;
            r_dropped <= w_push && w_full && !w_pop;
        end
    end

    ir_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign evt_valid   = !w_empty;
    assign w_pop       = evt_valid && evt_ready;
    assign evt_code    = evt_valid ? w_head[7:0] : 8'd0;
    assign evt_type    = evt_valid ? w_head[9:8] : 2'd0;
    assign key_down    = r_key_down;
    assign key_code    = r_key_code;
    assign evt_dropped = r_dropped;
    assign fifo_count  = w_count;

endmodule
